man_render_datapath: RTL and testbench
======================================

// Module: man_render_datapath
// PURPOSE
//  Datapath that executes the running-man game controller's commands. For each command it generates the
//  VGA-adapter pixel stream (x, y, colour) and returns the matching *_finish signal. Commands are
//  floor draw, man erase, position update, style load and man draw. Also owns the frame-pace counter the
//  controller waits on. Sits between the controller FSM and the VGA adapter; writeEn stays with the FSM.
// PARAMETERS
//  SCREEN_W      160     screen width in pixels
//  SCREEN_H      120     screen height in pixels
//  FLOOR_Y       100     first floor row; floor spans rows FLOOR_Y..SCREEN_H-1, all columns
//  MAN_W         8       sprite width
//  MAN_H         16      sprite height
//  X_STEP        2       pixels advanced per update
//  FRAME_TICKS   833333  clk cycles per frame tick (50 MHz / 60)
//  BG_COLOUR     3'b000  background/erase colour
//  FLOOR_COLOUR  3'b010  floor colour
//  MAN_COLOUR    3'b111  sprite foreground colour
// PORTS
//  clk                  in   1  system clock
//  reset_n              in   1  asynchronous active-low reset
//  drawing_floors       in   1  floor sweep active
//  erase                in   1  erase sweep over man bounding box active
//  draw_man             in   1  sprite sweep active
//  ld_x                 in   1  latch draw origin x from position register
//  ld_y                 in   1  latch draw origin y from position register
//  ld_man_style         in   1  toggle animation style bit
//  update               in   1  advance man position by X_STEP
//  reset_frame_counter  in   1  ACTIVE-LOW synchronous clear of frame divider and frameCounter
//  x                    out  8  pixel column
//  y                    out  7  pixel row
//  colour               out  3  pixel colour
//  draw_floors_finish   out  1  high while the last floor pixel is presented
//  erase_finish         out  1  high while the last erase pixel is presented
//  draw_man_finish      out  1  high while the last sprite pixel is presented
//  frameCounter         out  4  frame ticks since last clear
// BEHAVIOUR
//  Reset: pos_x=0, pos_y=FLOOR_Y-MAN_H, org_x=0, org_y=FLOOR_Y-MAN_H, style=0, sweep cnt=0, divider=0,
//   frameCounter=0. Outputs follow from these: x=0, y=0, colour=BG_COLOUR, all finish=0.
//  Mode priority when several are high: drawing_floors > erase > draw_man. With none high: x=0, y=0, colour=BG.
//  Sweep: one counter pair (col,row) in raster order, col fastest. It advances 1 pixel per clk while the
//   selected mode is high. It clears to 0 on the cycle after the last pixel, and whenever no mode is high.
//   A mode dropped mid-sweep restarts at pixel 0.
//  x/y/colour/finish are combinational from registered state: 0-cycle latency, aligned with the FSM's writeEn.
//  Floor: x=col, y=FLOOR_Y+row, colour=FLOOR_COLOUR. Length SCREEN_W*(SCREEN_H-FLOOR_Y) = 3200 cycles.
//  Man: x=org_x+col, y=org_y+row. colour=MAN_COLOUR if sprite bit(style,row,col) else BG_COLOUR.
//   Erase: same box, colour=BG_COLOUR. Each is MAN_W*MAN_H = 128 cycles.
//  finish = mode active AND at last pixel. It is never registered, so it is high exactly 1 cycle per sweep.
//  ld_x/ld_y: org_x<=pos_x / org_y<=pos_y. ld_man_style: style<=~style. All apply on the next edge.
//  update: pos_x<=pos_x+X_STEP. If the result exceeds SCREEN_W-MAN_W, pos_x wraps to 0. pos_y is unchanged.
//  Erase uses org_x/org_y, so it erases where the man was last drawn even after update.
//  Frame pace: divider counts 0..FRAME_TICKS-1. On wrap, frameCounter increments, 15 wraps to 0.
//   reset_frame_counter==0 clears divider and frameCounter on the next edge; the clear wins over the increment.
//  Async reset mid-sweep: immediate return to reset values; no finish is emitted.
// STRUCTURE
//  Shared package: SCREEN_W/H, FLOOR_Y, MAN_W/H and the colour constants.
//   The controller and this block use the same values.
//  Sub-module man_sprite_rom: combinational (style, row[3:0], col[2:0]) -> pixel bit, 2x16x8 table.
//  Top holds position/origin/style regs, sweep counter, frame divider, output mux.
// TESTING
//  Use FRAME_TICKS=4 for sim.
//  1 Reset, then drawing_floors held: pixel 0=(0,100,010), pixel 3199=(159,119,010).
//    draw_floors_finish is high on cycle 3199 only, then the counter reads 0.
//  2 ld_x/ld_y then draw_man for 128 cycles: coords span (0..7, 84..99), colours match the ROM for style 0.
//    draw_man_finish is high at (7,99).
//  3 update x3 with pos_x=148, X_STEP=2: pos_x goes 150, 152, then 0 (wrap).
//    An erase run in between sweeps the old org box in BG colour.
//  4 ld_man_style twice: style goes 1 then 0. A sprite draw after the first toggle shows the style-1 pattern.
//  5 Free-run: frameCounter reaches 14 after 56 cycles.
//    Pulse reset_frame_counter=0 at the same edge as a tick: frameCounter=0 next cycle.
//  6 Assert reset_n=0 at pixel 50 of an erase: outputs drop to reset values asynchronously.
//    After release, erase restarts at pixel 0 and erase_finish appears after 128 cycles.

Source files
------------

// File: rtl/man_render_datapath_pkg.sv
// Shared constants for the running-man game: screen geometry, sprite size,
// step size and palette. The controller FSM imports the same package so both
// sides agree on sweep lengths. Also holds the sweep-mode type and its
// priority decoder.
package man_render_datapath_pkg;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int FLOOR_Y    = 100;
  localparam int MAN_W      = 8;
  localparam int MAN_H      = 16;
  localparam int X_STEP     = 2;
  localparam int FLOOR_ROWS = SCREEN_H - FLOOR_Y;
  // Largest legal left edge that keeps the whole sprite on screen.
  localparam int X_MAX      = SCREEN_W - MAN_W;

  localparam logic [2:0] BG_COLOUR    = 3'b000;
  localparam logic [2:0] FLOOR_COLOUR = 3'b010;
  localparam logic [2:0] MAN_COLOUR   = 3'b111;

  typedef enum logic [1:0] {
    MODE_NONE,
    MODE_FLOOR,
    MODE_ERASE,
    MODE_MAN
  } mode_e;

  // Floor beats erase beats man when the controller raises several at once.
  function automatic mode_e select_mode(logic drawing_floors, logic erase, logic draw_man);
    if (drawing_floors) return MODE_FLOOR;
    if (erase)          return MODE_ERASE;
    if (draw_man)       return MODE_MAN;
    return MODE_NONE;
  endfunction

endpackage

// File: rtl/man_render_datapath_if.sv
// Command/pixel bundle between the game controller and the render datapath.
//   Commands (controller -> datapath): drawing_floors, erase, draw_man, ld_x,
//     ld_y, ld_man_style, update, reset_frame_counter (active-low clear).
//   Results (datapath -> controller/VGA): x[7:0], y[6:0], colour[2:0],
//     draw_floors_finish, erase_finish, draw_man_finish, frameCounter[3:0].
interface man_render_datapath_if;

  logic       drawing_floors;
  logic       erase;
  logic       draw_man;
  logic       ld_x;
  logic       ld_y;
  logic       ld_man_style;
  logic       update;
  logic       reset_frame_counter;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       draw_floors_finish;
  logic       erase_finish;
  logic       draw_man_finish;
  logic [3:0] frameCounter;

  modport master (
    output drawing_floors, erase, draw_man, ld_x, ld_y, ld_man_style, update,
           reset_frame_counter,
    input  x, y, colour, draw_floors_finish, erase_finish, draw_man_finish, frameCounter
  );

  modport slave (
    input  drawing_floors, erase, draw_man, ld_x, ld_y, ld_man_style, update,
           reset_frame_counter,
    output x, y, colour, draw_floors_finish, erase_finish, draw_man_finish, frameCounter
  );

endinterface

// File: rtl/man_render_datapath_sprite_rom.sv
// Running-man sprite table, two animation frames of 16 rows x 8 columns.
//   style  in 1  animation frame select
//   row    in 4  sprite row (0 = top)
//   col    in 3  sprite column (0 = left)
//   pixel  out 1 1 = foreground
// Each row byte is stored MSB-left, so column 0 is bit 7.
module man_sprite_rom (
  input  logic       style,
  input  logic [3:0] row,
  input  logic [2:0] col,
  output logic       pixel
);

  logic [7:0] row_bits;

  always_comb begin
    row_bits = 8'h00;
    case ({style, row})
      // style 0: legs apart
      5'h00: row_bits = 8'h18;  5'h01: row_bits = 8'h3C;
      5'h02: row_bits = 8'h3C;  5'h03: row_bits = 8'h18;
      5'h04: row_bits = 8'h7E;  5'h05: row_bits = 8'hBD;
      5'h06: row_bits = 8'hBD;  5'h07: row_bits = 8'h3C;
      5'h08: row_bits = 8'h3C;  5'h09: row_bits = 8'h24;
      5'h0A: row_bits = 8'h24;  5'h0B: row_bits = 8'h42;
      5'h0C: row_bits = 8'h42;  5'h0D: row_bits = 8'h81;
      5'h0E: row_bits = 8'h81;  5'h0F: row_bits = 8'hC3;
      // style 1: legs together
      5'h10: row_bits = 8'h18;  5'h11: row_bits = 8'h3C;
      5'h12: row_bits = 8'h3C;  5'h13: row_bits = 8'h18;
      5'h14: row_bits = 8'h3C;  5'h15: row_bits = 8'h7E;
      5'h16: row_bits = 8'h7E;  5'h17: row_bits = 8'h3C;
      5'h18: row_bits = 8'h3C;  5'h19: row_bits = 8'h18;
      5'h1A: row_bits = 8'h18;  5'h1B: row_bits = 8'h18;
      5'h1C: row_bits = 8'h18;  5'h1D: row_bits = 8'h18;
      5'h1E: row_bits = 8'h18;  5'h1F: row_bits = 8'h3C;
      default: row_bits = 8'h00;
    endcase
  end

  assign pixel = row_bits[3'd7 - col];

endmodule

// File: rtl/man_render_datapath.sv
// Render datapath for the running-man controller. Turns sweep commands into
// a VGA pixel stream (x, y, colour) with a one-cycle finish flag on the last
// pixel, keeps man position/draw-origin/animation style, and runs the frame
// pacing divider.
//   clk, reset_n  clock, asynchronous active-low reset
//   bus (slave)   commands in; x/y/colour, *_finish, frameCounter out
// Parameter FRAME_TICKS: clk cycles per frameCounter increment.
module man_render_datapath
  import man_render_datapath_pkg::*;
#(
  parameter int FRAME_TICKS = 833333
) (
  input  logic                 clk,
  input  logic                 reset_n,
  man_render_datapath_if.slave bus
);

  localparam int              DIV_W    = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_TICKS - 1);

  logic [7:0]       pos_x_reg, org_x_reg;
  logic [6:0]       pos_y_reg, org_y_reg;
  logic             style_reg;
  logic [7:0]       col_reg, col_cur, col_next, last_col;
  logic [6:0]       row_reg, row_cur, row_next, last_row;
  mode_e            mode, mode_reg;
  logic             at_last;
  logic             sprite_bit;
  logic [8:0]       pos_x_sum;
  logic [7:0]       pos_x_stepped;
  logic [DIV_W-1:0] div_reg;
  logic [3:0]       frame_cnt_reg;

  // Sweep counter. A change of mode (including a drop to none) makes the
  // stored count stale, so the current pixel is forced back to 0.
  always_comb begin
    mode     = select_mode(bus.drawing_floors, bus.erase, bus.draw_man);
    col_cur  = (mode == mode_reg) ? col_reg : 8'd0;
    row_cur  = (mode == mode_reg) ? row_reg : 7'd0;
    if (mode == MODE_FLOOR) begin
      last_col = 8'(SCREEN_W - 1);
      last_row = 7'(FLOOR_ROWS - 1);
    end else begin
      last_col = 8'(MAN_W - 1);
      last_row = 7'(MAN_H - 1);
    end
    at_last  = (mode != MODE_NONE) && (col_cur == last_col) && (row_cur == last_row);
    col_next = 8'd0;
    row_next = 7'd0;
    if (mode != MODE_NONE && !at_last) begin
      if (col_cur == last_col) begin
        row_next = row_cur + 7'd1;
      end else begin
        col_next = col_cur + 8'd1;
        row_next = row_cur;
      end
    end
  end

  man_sprite_rom u_sprite_rom (
    .style (style_reg),
    .row   (row_cur[3:0]),
    .col   (col_cur[2:0]),
    .pixel (sprite_bit)
  );

  // Pixel mux is purely combinational so it lines up with the controller's
  // writeEn in the same cycle.
  always_comb begin
    bus.x                  = 8'd0;
    bus.y                  = 7'd0;
    bus.colour             = BG_COLOUR;
    bus.draw_floors_finish = 1'b0;
    bus.erase_finish       = 1'b0;
    bus.draw_man_finish    = 1'b0;
    case (mode)
      MODE_FLOOR: begin
        bus.x                  = col_cur;
        bus.y                  = 7'(FLOOR_Y) + row_cur;
        bus.colour             = FLOOR_COLOUR;
        bus.draw_floors_finish = at_last;
      end
      MODE_ERASE: begin
        bus.x            = org_x_reg + col_cur;
        bus.y            = org_y_reg + row_cur;
        bus.erase_finish = at_last;
      end
      MODE_MAN: begin
        bus.x               = org_x_reg + col_cur;
        bus.y               = org_y_reg + row_cur;
        bus.colour          = sprite_bit ? MAN_COLOUR : BG_COLOUR;
        bus.draw_man_finish = at_last;
      end
      default: ;
    endcase
  end

  // Step right; any left edge past X_MAX would clip the sprite, so wrap to 0.
  assign pos_x_sum     = {1'b0, pos_x_reg} + 9'(X_STEP);
  assign pos_x_stepped = (pos_x_sum > 9'(X_MAX)) ? 8'd0 : pos_x_sum[7:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_x_reg <= 8'd0;
      pos_y_reg <= 7'(FLOOR_Y - MAN_H);
      org_x_reg <= 8'd0;
      org_y_reg <= 7'(FLOOR_Y - MAN_H);
      style_reg <= 1'b0;
      col_reg   <= 8'd0;
      row_reg   <= 7'd0;
      mode_reg  <= MODE_NONE;
    end else begin
      col_reg  <= col_next;
      row_reg  <= row_next;
      mode_reg <= mode;
      if (bus.update)       pos_x_reg <= pos_x_stepped;
      if (bus.ld_x)         org_x_reg <= pos_x_reg;
      if (bus.ld_y)         org_y_reg <= pos_y_reg;
      if (bus.ld_man_style) style_reg <= ~style_reg;
    end
  end

  // Frame pacing; the active-low clear takes precedence over a tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg       <= '0;
      frame_cnt_reg <= 4'd0;
    end else if (!bus.reset_frame_counter) begin
      div_reg       <= '0;
      frame_cnt_reg <= 4'd0;
    end else if (div_reg == DIV_LAST) begin
      div_reg       <= '0;
      frame_cnt_reg <= frame_cnt_reg + 4'd1;
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

  assign bus.frameCounter = frame_cnt_reg;

endmodule

// File: tb/tb_man_render_datapath.sv
module tb_man_render_datapath;

  localparam int P_LD     = 0;
  localparam int P_STYLE  = 1;
  localparam int P_UPDATE = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  man_render_datapath_if bus();

  man_render_datapath #(.FRAME_TICKS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  int m_pos_x, m_org_x, m_org_y, m_style;
  logic [7:0] spr [32];

  initial begin
    spr[0]='h18;  spr[1]='h3C;  spr[2]='h3C;  spr[3]='h18;
    spr[4]='h7E;  spr[5]='hBD;  spr[6]='hBD;  spr[7]='h3C;
    spr[8]='h3C;  spr[9]='h24;  spr[10]='h24; spr[11]='h42;
    spr[12]='h42; spr[13]='h81; spr[14]='h81; spr[15]='hC3;
    spr[16]='h18; spr[17]='h3C; spr[18]='h3C; spr[19]='h18;
    spr[20]='h3C; spr[21]='h7E; spr[22]='h7E; spr[23]='h3C;
    spr[24]='h3C; spr[25]='h18; spr[26]='h18; spr[27]='h18;
    spr[28]='h18; spr[29]='h18; spr[30]='h18; spr[31]='h3C;
  end

  function automatic bit sprite_on(int style, int row, int col);
    logic [7:0] bits;
    bits = spr[style*16 + row];
    return bits[7-col];
  endfunction

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.drawing_floors = 1'b0; bus.erase = 1'b0; bus.draw_man = 1'b0;
    bus.ld_x = 1'b0; bus.ld_y = 1'b0; bus.ld_man_style = 1'b0;
    bus.update = 1'b0; bus.reset_frame_counter = 1'b1;
  endtask

  task automatic model_reset();
    m_pos_x = 0; m_org_x = 0; m_org_y = 84; m_style = 0;
  endtask

  // One-cycle command pulse, then the model applies the same rule.
  task automatic pulse(input int which);
    case (which)
      P_LD:     begin bus.ld_x = 1'b1; bus.ld_y = 1'b1; end
      P_STYLE:  bus.ld_man_style = 1'b1;
      default:  bus.update = 1'b1;
    endcase
    advance();
    bus.ld_x = 1'b0; bus.ld_y = 1'b0; bus.ld_man_style = 1'b0; bus.update = 1'b0;
    case (which)
      P_LD:    begin m_org_x = m_pos_x; m_org_y = 84; end
      P_STYLE: m_style = 1 - m_style;
      default: begin
        m_pos_x = m_pos_x + 2;
        if (m_pos_x > 160 - 8) m_pos_x = 0;
      end
    endcase
  endtask

  // Erase or sprite sweep of len pixels starting at pixel 0, then mode drop.
  task automatic run_box_sweep(input bit is_erase, input int len, input string tag);
    logic [20:0] got, expv;
    int col, row;
    logic [2:0] ecol;
    if (is_erase) bus.erase = 1'b1; else bus.draw_man = 1'b1;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      col  = k % 8;
      row  = k / 8;
      ecol = (!is_erase && sprite_on(m_style, row, col)) ? 3'b111 : 3'b000;
      expv = {8'(m_org_x + col), 7'(m_org_y + row), ecol,
              1'b0, is_erase && k == 127, !is_erase && k == 127};
      got  = {bus.x, bus.y, bus.colour, bus.draw_floors_finish, bus.erase_finish, bus.draw_man_finish};
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL %s k=%0d: got x=%0d y=%0d c=%b fin=%b, expected x=%0d y=%0d c=%b fin=%b",
                 tag, k, got[20:13], got[12:6], got[5:3], got[2:0],
                 expv[20:13], expv[12:6], expv[5:3], expv[2:0]);
      end
      advance();
    end
    bus.erase = 1'b0; bus.draw_man = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compared++;
    if (bus.x !== 8'd0) begin mismatched++; $display("FAIL reset_x: got %0d expected 0", bus.x); end
    compared++;
    if (bus.y !== 7'd0) begin mismatched++; $display("FAIL reset_y: got %0d expected 0", bus.y); end
    compared++;
    if (bus.colour !== 3'b000) begin mismatched++; $display("FAIL reset_colour: got %b expected 000", bus.colour); end
    compared++;
    if ({bus.draw_floors_finish, bus.erase_finish, bus.draw_man_finish} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_finish: got %b expected 000",
               {bus.draw_floors_finish, bus.erase_finish, bus.draw_man_finish});
    end
    compared++;
    if (bus.frameCounter !== 4'd0) begin mismatched++; $display("FAIL reset_frame: got %0d expected 0", bus.frameCounter); end
    advance();
    reset_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_floor();
    logic [20:0] got, expv;
    int kk;
    bus.drawing_floors = 1'b1;
    // One extra pixel past the end: the sweep must have restarted at 0.
    for (int k = 0; k <= 3200; k++) begin
      @(negedge clk);
      kk   = k % 3200;
      expv = {8'(kk % 160), 7'(100 + kk / 160), 3'b010, kk == 3199, 1'b0, 1'b0};
      got  = {bus.x, bus.y, bus.colour, bus.draw_floors_finish, bus.erase_finish, bus.draw_man_finish};
      compared++;
      if (got !== expv) begin
        mismatched++;
        $display("FAIL floor k=%0d: got x=%0d y=%0d c=%b fin=%b, expected x=%0d y=%0d c=%b fin=%b",
                 k, got[20:13], got[12:6], got[5:3], got[2:0],
                 expv[20:13], expv[12:6], expv[5:3], expv[2:0]);
      end
      advance();
    end
    bus.drawing_floors = 1'b0;
    @(negedge clk);
    compared++;
    if ({bus.x, bus.y, bus.colour} !== 18'd0) begin
      mismatched++;
      $display("FAIL idle_after_floor: got x=%0d y=%0d c=%b expected 0 0 000", bus.x, bus.y, bus.colour);
    end
    advance();
    $display("test_floor done");
  endtask

  task automatic test_draw_man();
    pulse(P_LD);
    run_box_sweep(1'b0, 128, "man_style0");
    $display("test_draw_man done org=(%0d,%0d)", m_org_x, m_org_y);
  endtask

  task automatic test_update_wrap();
    int exp_x [3];
    exp_x[0] = 150; exp_x[1] = 152; exp_x[2] = 0;
    for (int g = 0; g < 200 && m_pos_x != 148; g++) pulse(P_UPDATE);
    pulse(P_LD);
    run_box_sweep(1'b0, 128, "man_at148");
    for (int i = 0; i < 3; i++) begin
      pulse(P_UPDATE);
      run_box_sweep(1'b1, 128, "erase_old_org");
      pulse(P_LD);
      bus.draw_man = 1'b1;
      @(negedge clk);
      compared++;
      if (bus.x !== 8'(exp_x[i])) begin
        mismatched++;
        $display("FAIL update_wrap step %0d: got x=%0d expected %0d", i, bus.x, exp_x[i]);
      end
      advance();
      bus.draw_man = 1'b0;
      advance();
      $display("test_update_wrap step %0d pos_x=%0d", i, m_pos_x);
    end
  endtask

  task automatic test_style();
    pulse(P_STYLE);
    run_box_sweep(1'b0, 128, "man_style1");
    pulse(P_STYLE);
    run_box_sweep(1'b0, 128, "man_style0_again");
    $display("test_style done");
  endtask

  task automatic test_random();
    int op, n;
    bit e;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          n = $urandom_range(1, 12);
          for (int j = 0; j < n; j++) pulse(P_UPDATE);
        end
        1: pulse(P_LD);
        2: pulse(P_STYLE);
        3: run_box_sweep(1'b0, 128, "rand_man");
        4: run_box_sweep(1'b1, 128, "rand_erase");
        default: begin
          e = 1'($urandom_range(0, 1));
          run_box_sweep(e, $urandom_range(1, 127), "rand_abort");
          if ($urandom_range(0, 1) != 0) advance();
          run_box_sweep(!e, 128, "rand_restart");
        end
      endcase
      $display("test_random it=%0d op=%0d pos_x=%0d org_x=%0d style=%0d", it, op, m_pos_x, m_org_x, m_style);
    end
  endtask

  task automatic test_frame();
    bus.reset_frame_counter = 1'b0;
    advance();
    bus.reset_frame_counter = 1'b1;
    for (int m = 0; m < 60; m++) begin
      @(negedge clk);
      compared++;
      if (bus.frameCounter !== 4'((m / 4) % 16)) begin
        mismatched++;
        $display("FAIL frame_run m=%0d: got %0d expected %0d", m, bus.frameCounter, (m / 4) % 16);
      end
      // Edge ending m=59 is also a divider wrap: the clear must win.
      if (m == 59) bus.reset_frame_counter = 1'b0;
      advance();
    end
    bus.reset_frame_counter = 1'b1;
    for (int m = 0; m < 9; m++) begin
      @(negedge clk);
      compared++;
      if (bus.frameCounter !== 4'(m / 4)) begin
        mismatched++;
        $display("FAIL frame_clear m=%0d: got %0d expected %0d", m, bus.frameCounter, m / 4);
      end
      advance();
    end
    $display("test_frame done");
  endtask

  task automatic test_async_reset();
    pulse(P_UPDATE); pulse(P_UPDATE); pulse(P_UPDATE);
    pulse(P_LD);
    pulse(P_STYLE);
    bus.erase = 1'b1;
    repeat (50) advance();
    #2;
    reset_n = 1'b0;
    #1;
    compared++;
    if ({bus.x, bus.y, bus.colour, bus.erase_finish} !== {8'd0, 7'd84, 3'b000, 1'b0}) begin
      mismatched++;
      $display("FAIL async_reset_erase: got x=%0d y=%0d c=%b fin=%b expected x=0 y=84 c=000 fin=0",
               bus.x, bus.y, bus.colour, bus.erase_finish);
    end
    compared++;
    if (bus.frameCounter !== 4'd0) begin
      mismatched++;
      $display("FAIL async_reset_frame: got %0d expected 0", bus.frameCounter);
    end
    bus.erase = 1'b0;
    #1;
    compared++;
    if ({bus.x, bus.y, bus.colour} !== 18'd0) begin
      mismatched++;
      $display("FAIL async_reset_idle: got x=%0d y=%0d c=%b expected 0 0 000", bus.x, bus.y, bus.colour);
    end
    model_reset();
    advance();
    reset_n = 1'b1;
    run_box_sweep(1'b1, 128, "erase_after_reset");
    run_box_sweep(1'b0, 128, "man_after_reset");
    $display("test_async_reset done");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_floor();
    test_draw_man();
    test_update_wrap();
    test_style();
    test_random();
    test_frame();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
